sobel_frame_ctrl: RTL
=====================

Name: sobel_frame_ctrl

Overview:
Frame sequencer that feeds the sobel edge filter. It takes pixels from an upstream source with a valid/ready handshake and produces the filter's gray_valid/gray_data/hsync/vsync timing, including vertical and horizontal blanking. It also owns the edge-threshold configuration, applied only at frame boundaries, and counts the filter's output pixels. One instance sits between the frame-buffer reader and the sobel filter.

Parameters:
IMG_W, 320, active pixels per line
IMG_H, 240, active lines per frame
HBLANK, 16, idle cycles after each line; hsync is high for the first HS_LEN of them
HS_LEN, 4, hsync pulse width in cycles (must be ≤ HBLANK)
VS_LEN, 8, vsync pulse width in cycles at frame start
DRAIN, 8, cycles waited after the last pixel so the filter pipeline can flush

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle frame start request
abort  in  1  single-cycle frame abort
thresh_in  in  8  new edge threshold value
thresh_we  in  1  write strobe for thresh_in into the shadow register
src_valid  in  1  upstream pixel valid
src_data  in  8  upstream gray pixel
src_ready  out  1  controller accepts a pixel this cycle
gray_valid  out  1  pixel strobe to the filter
gray_data  out  8  pixel to the filter
hsync  out  1  line sync to the filter, active high
vsync  out  1  frame sync to the filter, active high
edge_threshold  out  8  active threshold driven to the filter
sobel_valid  in  1  filter output strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame completion
out_cnt  out  18  number of sobel_valid cycles counted in the current or last frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values:
  - src_ready, gray_valid, hsync, vsync, busy, done = 0.
  - gray_data = 0; out_cnt = 0.
  - edge_threshold and the shadow register = 100.
  - State = IDLE; all counters = 0.
- All outputs are registered.
- Shadow threshold:
  - thresh_we loads thresh_in into the shadow on the next edge, in any state.
  - edge_threshold takes the shadow value only on the IDLE→VS transition; it is held constant for the whole frame.
  - If thresh_we and start occur in the same cycle, the new value is used for that frame.
- States:
  - IDLE: start → VS. Start while busy is ignored.
  - VS: vsync = 1 for exactly VS_LEN cycles, then → ACT. Row and column counters and out_cnt are cleared on entry.
  - ACT: src_ready = 1.
    - A transfer is src_valid & src_ready. Each transfer sets gray_valid = 1 and gray_data = src_data on the next cycle, so latency is 1.
    - src_valid low inserts a bubble (gray_valid = 0) with no column advance.
    - The transfer with col == IMG_W-1 → HB. src_ready drops in the following cycle, so no pixel beyond IMG_W is accepted.
  - HB: src_ready = 0; lasts exactly HBLANK cycles; hsync = 1 for the first HS_LEN of them. At the end:
    - if row == IMG_H-1 → DR;
    - otherwise row++, col = 0, → ACT.
  - DR: wait DRAIN cycles; hsync and vsync stay 0. Then → IDLE, with done = 1 for one cycle and busy = 0 on that same cycle.
- out_cnt:
  - Increments on every sobel_valid cycle while busy, including DR.
  - Saturates at 2^18-1.
  - Holds its value in IDLE until the next frame's VS entry.
- abort:
  - In any busy state: → IDLE next cycle. src_ready, gray_valid, hsync and vsync go to 0; done is not pulsed; out_cnt is held.
  - abort together with start in IDLE: abort wins, no frame starts.
- rst mid-frame restores all reset values, including the shadow and edge_threshold returning to 100.
- Widths: column counter is clog2(IMG_W); row counter is clog2(IMG_H); blank/sync/drain counter is wide enough for max(HBLANK, VS_LEN, DRAIN).

Test Plan:
1. Basic frame. IMG_W=4, IMG_H=3, HBLANK=3, HS_LEN=1, VS_LEN=2, DRAIN=4; src_valid held high; start pulse → vsync high 2 cycles; 3 bursts of 4 gray_valid pixels, each followed by 3 blank cycles with hsync high on the first; done exactly 4 cycles after the last HB; busy high from the cycle after start until the done cycle.
2. Backpressure bubbles. Same params; src_valid toggles 1,0,1,0 → gray_valid mirrors accepted pixels one cycle later; exactly 4 pixels per line, data order preserved (send 10,20,30,40 → receive 10,20,30,40).
3. Threshold shadowing. Write 50 mid-frame → edge_threshold stays 100 until the next start, then becomes 50. thresh_we=1 with thresh_in=77 in the same cycle as start → edge_threshold = 77 for that frame.
4. Abort. abort during line 2 ACT → next cycle busy=0, src_ready=0, gray_valid=0, no done pulse. A new start runs a full, correct frame.
5. Output counting. Drive sobel_valid for 6 cycles during the frame and 2 during DR → out_cnt = 8 at done, held in IDLE, cleared to 0 on the next VS entry.
6. Reset mid-frame. rst asserted in HB with shadow = 50 → all outputs return to reset values next cycle, edge_threshold = 100; start ignored while rst is high.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer in front of the sobel edge filter.
// Accepts pixels over a valid/ready handshake and produces the filter's
// gray_valid/gray_data/hsync/vsync timing, including horizontal and vertical
// blanking. It also owns the frame-synchronous edge threshold and counts the
// filter's output strobes.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int HBLANK = 16,
    parameter int HS_LEN = 4,
    parameter int VS_LEN = 8,
    parameter int DRAIN  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  thresh_in,
    input  logic        thresh_we,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        gray_valid,
    output logic [7:0]  gray_data,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  edge_threshold,
    input  logic        sobel_valid,
    output logic        busy,
    output logic        done,
    output logic [17:0] out_cnt
);

    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int MAX_HV  = (HBLANK > VS_LEN) ? HBLANK : VS_LEN;
    localparam int CNT_MAX = (MAX_HV > DRAIN) ? MAX_HV : DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] HS_LIM   = CNT_W'(HS_LEN);
    localparam logic [7:0]       THR_RST  = 8'd100;

    typedef enum logic [2:0] {S_IDLE, S_VS, S_ACT, S_HB, S_DR} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        src_ready_q, src_ready_d;
    logic        gray_valid_q, gray_valid_d;
    logic [7:0]  gray_data_q, gray_data_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  thresh_q, thresh_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [17:0] out_cnt_q, out_cnt_d;

    logic xfer;
    logic frame_start;

    // src_ready_q is high exactly while in ACT, so it qualifies the handshake
    assign xfer        = src_ready_q & src_valid;
    assign frame_start = (state_q == S_IDLE) && (state_d == S_VS);

    // State and position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: frame walk VS -> (ACT -> HB) x IMG_H -> DR -> IDLE, abort wins
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_VS;
                        col_d   = '0;
                        row_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_VS: begin
                    if (cnt_q == VS_LAST) begin
                        state_d = S_ACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    if (xfer) begin
                        if (col_q == COL_LAST) begin
                            state_d = S_HB;
                            cnt_d   = '0;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                S_HB: begin
                    if (cnt_q == HB_LAST) begin
                        cnt_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DR;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            col_d   = '0;
                            state_d = S_ACT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DR: begin
                    if (cnt_q == DR_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output next values, derived from the upcoming state so outputs stay registered
    always_comb begin
        src_ready_d  = (state_d == S_ACT);
        vsync_d      = (state_d == S_VS);
        hsync_d      = (state_d == S_HB) && (cnt_d < HS_LIM);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_q == S_DR) && (state_d == S_IDLE) && !abort;
        gray_valid_d = xfer && !abort;
        gray_data_d  = (xfer && !abort) ? src_data : gray_data_q;
        shadow_d     = thresh_we ? thresh_in : shadow_q;
        thresh_d     = thresh_q;
        if (frame_start) begin
            thresh_d = thresh_we ? thresh_in : shadow_q;
        end
        out_cnt_d = out_cnt_q;
        if (frame_start) begin
            out_cnt_d = '0;
        end else if (state_q != S_IDLE && !abort && sobel_valid && out_cnt_q != '1) begin
            out_cnt_d = out_cnt_q + 18'd1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ready_q  <= 1'b0;
            gray_valid_q <= 1'b0;
            gray_data_q  <= 8'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            thresh_q     <= THR_RST;
            shadow_q     <= THR_RST;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_cnt_q    <= 18'd0;
        end else begin
            src_ready_q  <= src_ready_d;
            gray_valid_q <= gray_valid_d;
            gray_data_q  <= gray_data_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            thresh_q     <= thresh_d;
            shadow_q     <= shadow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    assign src_ready      = src_ready_q;
    assign gray_valid     = gray_valid_q;
    assign gray_data      = gray_data_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign edge_threshold = thresh_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign out_cnt        = out_cnt_q;

endmodule
